// File: rtl/pipe_ctrl_2_if.sv
// Handshake bundle between the pipeline front end and pipe_ctrl_2.
// *_in: hazard/memory/trap status; *_out: enables, bubbles, pulses.
interface pipe_ctrl_2_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       s1_rs1_addr_in;
    logic [4:0]       s1_rs2_addr_in;
    logic             s1_rs1_used_in;
    logic             s1_rs2_used_in;
    logic [4:0]       s2_rd_addr_in;
    logic             s2_is_load_in;
    logic             s2_rf_wr_en_in;
    logic             branch_taken_in;
    logic             dmem_req_in;
    logic             dmem_ack_in;
    logic             trap_req_in;
    logic             stall_clr_in;
    logic             pc_en_out;
    logic             s1_en_out;
    logic             s2_en_out;
    logic             s1_flush_out;
    logic             s2_flush_out;
    logic             trap_ack_out;
    logic             bus_err_out;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] stall_cnt_out;

    modport master (
        output s1_rs1_addr_in, s1_rs2_addr_in,
        output s1_rs1_used_in, s1_rs2_used_in,
        output s2_rd_addr_in, s2_is_load_in,
        output s2_rf_wr_en_in, branch_taken_in,
        output dmem_req_in, dmem_ack_in,
        output trap_req_in, stall_clr_in,
        input  pc_en_out, s1_en_out, s2_en_out,
        input  s1_flush_out, s2_flush_out,
        input  trap_ack_out, bus_err_out,
        input  state_out, stall_cnt_out
    );

    modport slave (
        input  s1_rs1_addr_in, s1_rs2_addr_in,
        input  s1_rs1_used_in, s1_rs2_used_in,
        input  s2_rd_addr_in, s2_is_load_in,
        input  s2_rf_wr_en_in, branch_taken_in,
        input  dmem_req_in, dmem_ack_in,
        input  trap_req_in, stall_clr_in,
        output pc_en_out, s1_en_out, s2_en_out,
        output s1_flush_out, s2_flush_out,
        output trap_ack_out, bus_err_out,
        output state_out, stall_cnt_out
    );
endinterface

// File: rtl/pipe_ctrl_2.sv
// Pipeline sequencing controller: PC/stage-1/stage-2 enables and bubbles.
// Ports: clk_in, rst_in (async active-low), bus (pipe_ctrl_2_if.slave).
module pipe_ctrl_2 #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input logic          clk_in,
    input logic          rst_in,
    pipe_ctrl_2_if.slave bus
);
    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_MEMW = 3'd1;
    localparam logic [2:0] S_FLSH = 3'd2;
    localparam logic [2:0] S_TRAP = 3'd3;

    localparam logic [3:0] FL_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam bit         MULTI_FL = (FLUSH_CYCLES > 1);

    logic [2:0]       r_state;
    logic [2:0]       w_nxt_state;
    logic [3:0]       r_fl_cnt;
    logic [3:0]       w_nxt_fl;
    logic [7:0]       r_to_cnt;
    logic [7:0]       w_nxt_to;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_hazard;
    logic w_wait;
    logic w_pc_en;
    logic w_s1_en;
    logic w_s2_en;
    logic w_s1_fl;
    logic w_s2_fl;
    logic w_ack;
    logic w_berr;

    // Load-use: the load result is not available to stage 1 yet.
    assign w_hazard = bus.s2_is_load_in && bus.s2_rf_wr_en_in
        && (bus.s2_rd_addr_in != 5'd0)
        && ((bus.s1_rs1_used_in
             && (bus.s1_rs1_addr_in == bus.s2_rd_addr_in))
         || (bus.s1_rs2_used_in
             && (bus.s1_rs2_addr_in == bus.s2_rd_addr_in)));

    assign w_wait = bus.dmem_req_in && !bus.dmem_ack_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_RUN;
            r_fl_cnt <= 4'd0;
            r_to_cnt <= 8'd0;
        end else begin
            r_state  <= w_nxt_state;
            r_fl_cnt <= w_nxt_fl;
            r_to_cnt <= w_nxt_to;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_fl    = r_fl_cnt;
        w_nxt_to    = r_to_cnt;
        unique case (r_state)
            S_RUN: begin
                if (bus.trap_req_in) begin
                    w_nxt_state = S_TRAP;
                end else if (w_wait) begin
                    w_nxt_state = S_MEMW;
                    w_nxt_to    = 8'd1;
                end else if (bus.branch_taken_in && MULTI_FL) begin
                    w_nxt_state = S_FLSH;
                    w_nxt_fl    = FL_LOAD;
                end
            end
            S_MEMW: begin
                if (bus.dmem_ack_in) begin
                    w_nxt_state = S_RUN;
                    if (bus.branch_taken_in && MULTI_FL) begin
                        w_nxt_state = S_FLSH;
                        w_nxt_fl    = FL_LOAD;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_nxt_state = S_TRAP;
                end else begin
                    w_nxt_to = r_to_cnt + 8'd1;
                end
            end
            S_FLSH: begin
                w_nxt_fl = r_fl_cnt - 4'd1;
                if (r_fl_cnt == 4'd1) w_nxt_state = S_RUN;
            end
            S_TRAP: begin
                if (MULTI_FL) begin
                    w_nxt_state = S_FLSH;
                    w_nxt_fl    = FL_LOAD;
                end else begin
                    w_nxt_state = S_RUN;
                end
            end
            default: w_nxt_state = S_RUN;
        endcase
    end

    always_comb begin
        w_pc_en = 1'b1;
        w_s1_en = 1'b1;
        w_s2_en = 1'b1;
        w_s1_fl = 1'b0;
        w_s2_fl = 1'b0;
        w_ack   = 1'b0;
        w_berr  = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (bus.trap_req_in || w_wait) begin
                    {w_pc_en, w_s1_en, w_s2_en} = 3'b000;
                end else if (bus.branch_taken_in) begin
                    {w_s1_fl, w_s2_fl} = 2'b11;
                end else if (w_hazard) begin
                    {w_pc_en, w_s1_en, w_s2_fl} = 3'b001;
                end
            end
            S_MEMW: begin
                // The ack cycle behaves like an ordinary RUN cycle.
                if (bus.dmem_ack_in) begin
                    if (bus.branch_taken_in) begin
                        {w_s1_fl, w_s2_fl} = 2'b11;
                    end else if (w_hazard) begin
                        {w_pc_en, w_s1_en, w_s2_fl} = 3'b001;
                    end
                end else begin
                    {w_pc_en, w_s1_en, w_s2_en} = 3'b000;
                    w_berr = (r_to_cnt == TO_LAST);
                end
            end
            S_FLSH: w_s1_fl = 1'b1;
            S_TRAP: {w_s1_fl, w_s2_fl, w_ack} = 3'b111;
            default: ;
        endcase
        if (!rst_in) begin
            {w_pc_en, w_s1_en, w_s2_en} = 3'b000;
            {w_s1_fl, w_s2_fl}          = 2'b11;
            {w_ack, w_berr}             = 2'b00;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_stall_cnt <= '0;
        end else if (bus.stall_clr_in) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_en_out     = w_pc_en;
    assign bus.s1_en_out     = w_s1_en;
    assign bus.s2_en_out     = w_s2_en;
    assign bus.s1_flush_out  = w_s1_fl;
    assign bus.s2_flush_out  = w_s2_fl;
    assign bus.trap_ack_out  = w_ack;
    assign bus.bus_err_out   = w_berr;
    assign bus.state_out     = r_state;
    assign bus.stall_cnt_out = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl_2.sv
// Directed bench for pipe_ctrl_2 (FLUSH_CYCLES=2, MEM_TIMEOUT=16).
// Control vector order: pc_en,s1_en,s2_en,s1_fl,s2_fl,trap_ack,bus_err.
module tb_pipe_ctrl_2;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    localparam logic [6:0] C_RUN  = 7'b1110000;
    localparam logic [6:0] C_RST  = 7'b0001100;
    localparam logic [6:0] C_FRZ  = 7'b0000000;
    localparam logic [6:0] C_HAZ  = 7'b0010100;
    localparam logic [6:0] C_BR   = 7'b1111100;
    localparam logic [6:0] C_FL   = 7'b1111000;
    localparam logic [6:0] C_TRAP = 7'b1111110;
    localparam logic [6:0] C_BERR = 7'b0000001;

    pipe_ctrl_2_if #(.CNT_W(32)) bus ();

    pipe_ctrl_2 #(
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        #1;
        check(tag, 32'({bus.pc_en_out, bus.s1_en_out, bus.s2_en_out,
                        bus.s1_flush_out, bus.s2_flush_out,
                        bus.trap_ack_out, bus.bus_err_out}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_haz(input logic on, input logic [4:0] rd);
        bus.s2_is_load_in  = on;
        bus.s2_rf_wr_en_in = on;
        bus.s2_rd_addr_in  = rd;
        bus.s1_rs2_addr_in = rd;
        bus.s1_rs2_used_in = on;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.s1_rs1_addr_in  = 5'd0;
        bus.s1_rs2_addr_in  = 5'd0;
        bus.s1_rs1_used_in  = 1'b0;
        bus.s1_rs2_used_in  = 1'b0;
        bus.s2_rd_addr_in   = 5'd0;
        bus.s2_is_load_in   = 1'b0;
        bus.s2_rf_wr_en_in  = 1'b0;
        bus.branch_taken_in = 1'b0;
        bus.dmem_req_in     = 1'b0;
        bus.dmem_ack_in     = 1'b0;
        bus.trap_req_in     = 1'b0;
        bus.stall_clr_in    = 1'b0;

        chk_ctl("rst_ctl", C_RST);
        check("rst_state", 32'(bus.state_out), 0);
        check("rst_cnt", bus.stall_cnt_out, 0);
        #10 rst_n = 1'b1;
        tick();
        chk_ctl("idle_ctl", C_RUN);

        set_haz(1'b1, 5'd5);
        chk_ctl("lu_ctl", C_HAZ);
        check("lu_state", 32'(bus.state_out), 0);
        tick();
        set_haz(1'b0, 5'd0);
        chk_ctl("lu_after", C_RUN);
        check("lu_cnt", bus.stall_cnt_out, 1);

        set_haz(1'b1, 5'd0);
        chk_ctl("rd0_ctl", C_RUN);
        tick();
        set_haz(1'b0, 5'd0);
        check("rd0_cnt", bus.stall_cnt_out, 1);

        bus.s2_is_load_in  = 1'b1;
        bus.s2_rf_wr_en_in = 1'b1;
        bus.s2_rd_addr_in  = 5'd7;
        bus.s1_rs1_addr_in = 5'd7;
        chk_ctl("rs1_unused", C_RUN);
        bus.s1_rs1_used_in = 1'b1;
        chk_ctl("rs1_haz", C_HAZ);
        bus.stall_clr_in = 1'b1;
        tick();
        bus.stall_clr_in   = 1'b0;
        bus.s1_rs1_used_in = 1'b0;
        set_haz(1'b0, 5'd0);
        check("clr_wins", bus.stall_cnt_out, 0);

        bus.dmem_req_in = 1'b1;
        chk_ctl("mw_entry", C_FRZ);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("mw_state", 32'(bus.state_out), 1);
            chk_ctl("mw_ctl", C_FRZ);
            tick();
        end
        bus.dmem_ack_in = 1'b1;
        chk_ctl("mw_ack", C_RUN);
        tick();
        bus.dmem_req_in = 1'b0;
        bus.dmem_ack_in = 1'b0;
        check("mw_ret", 32'(bus.state_out), 0);
        check("mw_cnt", bus.stall_cnt_out, 4);

        bus.dmem_req_in = 1'b1;
        chk_ctl("to_entry", C_FRZ);
        tick();
        for (int i = 1; i < 15; i++) begin
            chk_ctl("to_wait", C_FRZ);
            tick();
        end
        check("to_st15", 32'(bus.state_out), 1);
        chk_ctl("to_berr", C_BERR);
        tick();
        bus.dmem_req_in = 1'b0;
        check("to_trap_st", 32'(bus.state_out), 3);
        chk_ctl("to_trap", C_TRAP);
        tick();
        check("to_fl_st", 32'(bus.state_out), 2);
        chk_ctl("to_fl", C_FL);
        tick();
        check("to_run_st", 32'(bus.state_out), 0);
        check("to_cnt", bus.stall_cnt_out, 20);

        bus.branch_taken_in = 1'b1;
        chk_ctl("br_ctl", C_BR);
        tick();
        bus.branch_taken_in = 1'b0;
        check("br_fl_st", 32'(bus.state_out), 2);
        bus.trap_req_in = 1'b1;
        set_haz(1'b1, 5'd5);
        chk_ctl("br_fl_ign", C_FL);
        tick();
        check("br_run_st", 32'(bus.state_out), 0);
        chk_ctl("br_frz", C_FRZ);
        tick();
        bus.trap_req_in = 1'b0;
        set_haz(1'b0, 5'd0);
        check("br_trap_st", 32'(bus.state_out), 3);
        chk_ctl("br_trap", C_TRAP);
        tick();
        chk_ctl("br_tr_fl", C_FL);
        tick();
        chk_ctl("br_tr_run", C_RUN);

        bus.trap_req_in     = 1'b1;
        bus.branch_taken_in = 1'b1;
        set_haz(1'b1, 5'd5);
        chk_ctl("pri_frz", C_FRZ);
        tick();
        bus.trap_req_in     = 1'b0;
        bus.branch_taken_in = 1'b0;
        set_haz(1'b0, 5'd0);
        check("pri_st", 32'(bus.state_out), 3);
        chk_ctl("pri_trap", C_TRAP);
        tick();
        tick();
        check("pri_run", 32'(bus.state_out), 0);

        bus.dmem_req_in = 1'b1;
        tick();
        bus.trap_req_in = 1'b1;
        chk_ctl("mwt_ign", C_FRZ);
        tick();
        check("mwt_st", 32'(bus.state_out), 1);
        bus.dmem_ack_in     = 1'b1;
        bus.branch_taken_in = 1'b1;
        chk_ctl("mwt_ackbr", C_BR);
        tick();
        bus.dmem_req_in     = 1'b0;
        bus.dmem_ack_in     = 1'b0;
        bus.branch_taken_in = 1'b0;
        check("mwt_fl", 32'(bus.state_out), 2);
        tick();
        chk_ctl("mwt_frz", C_FRZ);
        tick();
        bus.trap_req_in = 1'b0;
        chk_ctl("mwt_trap", C_TRAP);
        tick();
        tick();

        bus.dmem_req_in = 1'b1;
        tick();
        check("rmw_st", 32'(bus.state_out), 1);
        #1 rst_n = 1'b0;
        chk_ctl("rmw_ctl", C_RST);
        check("rmw_st0", 32'(bus.state_out), 0);
        check("rmw_cnt", bus.stall_cnt_out, 0);
        tick();
        bus.dmem_req_in = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("rel_st", 32'(bus.state_out), 0);
        check("rel_cnt", bus.stall_cnt_out, 0);
        chk_ctl("rel_ctl", C_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_2.md
Name: pipe_ctrl_2

Overview:
Pipeline sequencing controller for the stage-1/stage-2 pipeline registers and the PC.
- Generates per-register load enables and bubble (flush) controls.
- Handles load-use hazards, data-memory wait states, branch-taken flushes and the trap-entry handshake.
- Sits beside the stage-2 register block; all hazard and redirect decisions for the front end are made here.

Parameters:
FLUSH_CYCLES, 2, cycles s1_flush_out stays high after a redirect (1 + instruction-memory latency); legal range 1..15
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before a bus error; legal range 2..255
CNT_W, 32, width of stall_cnt_out

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous active-low reset
s1_rs1_addr_in  in  5  stage-1 source 1 address
s1_rs2_addr_in  in  5  stage-1 source 2 address
s1_rs1_used_in  in  1  stage-1 instruction reads rs1
s1_rs2_used_in  in  1  stage-1 instruction reads rs2
s2_rd_addr_in  in  5  stage-2 destination address
s2_is_load_in  in  1  stage-2 instruction is a load
s2_rf_wr_en_in  in  1  stage-2 instruction writes the register file
branch_taken_in  in  1  stage-2 branch/jump redirect
dmem_req_in  in  1  stage-2 data-memory access in progress
dmem_ack_in  in  1  data memory completes the access this cycle
trap_req_in  in  1  level trap request, held until trap_ack_out
stall_clr_in  in  1  synchronous clear of stall_cnt_out
pc_en_out  out  1  PC register load enable
s1_en_out  out  1  stage-1 register load enable
s2_en_out  out  1  stage-2 register load enable
s1_flush_out  out  1  stage-1 loads a bubble (dominates s1_en_out)
s2_flush_out  out  1  stage-2 loads a bubble (dominates s2_en_out)
trap_ack_out  out  1  one-cycle trap-entry pulse; PC loads the trap vector this cycle
bus_err_out  out  1  one-cycle memory-timeout pulse
state_out  out  3  current state encoding
stall_cnt_out  out  CNT_W  count of cycles with pc_en_out=0

Behaviour:
- State register encoding: RUN=0, MEM_WAIT=1, FLUSH=2, TRAP=3. Counters: fl_cnt (4 bits), to_cnt (8 bits).
- Outputs are a combinational decode of state and inputs (Mealy); the state and counters are registered.
- While rst_in=0: state=RUN, counters=0, stall_cnt_out=0. All enables are forced to 0, both flushes to 1, trap_ack_out=0 and bus_err_out=0. Reset applies immediately, including mid-wait or mid-flush.
- Definition: hazard = s2_is_load_in & s2_rf_wr_en_in & (s2_rd_addr_in!=0) & ((s1_rs1_used_in & rs1==rd) | (s1_rs2_used_in & rs2==rd)).
- Default outputs: all enables 1, flushes 0, pulses 0.

RUN priority, highest first:
1. trap_req_in: all enables 0 (freeze); next state TRAP.
2. dmem_req_in & !dmem_ack_in: all enables 0; to_cnt<=1; next state MEM_WAIT.
3. branch_taken_in: pc_en=1, s1_flush=1, s2_flush=1. If FLUSH_CYCLES>1, next state FLUSH with fl_cnt<=FLUSH_CYCLES-1; otherwise stay in RUN.
4. hazard: pc_en=0, s1_en=0, s2_flush=1 (one bubble); stay in RUN.

MEM_WAIT:
- All enables 0, flushes 0.
- dmem_ack_in: outputs equal the RUN decode of rules 3-4 (trap and memory-entry rules excluded); next state follows those rules, default RUN.
- No ack and to_cnt==MEM_TIMEOUT-1: bus_err_out=1; next state TRAP.
- No ack otherwise: to_cnt increments.
- trap_req_in is ignored here; it stays pending.

FLUSH:
- pc_en=1, s1_en=1, s2_en=1, s1_flush=1.
- fl_cnt decrements each cycle; at fl_cnt==1 the next state is RUN.
- branch_taken_in and hazard are ignored (stage 2 holds a bubble).
- A trap request is taken from RUN afterwards.

TRAP (exactly one cycle):
- pc_en=1, s1_flush=1, s2_flush=1, trap_ack_out=1.
- Next state FLUSH with fl_cnt<=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.

stall_cnt_out:
- Increments on every cycle with rst_in=1 and pc_en_out=0; saturates at all-ones.
- stall_clr_in clears it and wins over an increment in the same cycle.

Test Plan:
- Load-use: stage 2 holds a load to x5 (rd=5, rf_wr_en=1) and stage 1 uses rs2=5 -> one cycle with pc_en=0, s1_en=0, s2_flush=1, then normal flow; stall_cnt_out=1. Repeat with rd=0 -> no stall.
- Memory wait: dmem_req=1 with ack arriving after 3 cycles -> MEM_WAIT for 3 cycles with all enables 0; the ack cycle has enables 1 and state RUN next; stall_cnt_out=4.
- Timeout (MEM_TIMEOUT=16, no ack): bus_err_out pulses on the 16th cycle after entry -> TRAP with trap_ack_out=1 -> FLUSH for 1 cycle -> RUN.
- Branch with FLUSH_CYCLES=2: branch_taken for one cycle -> s1_flush high for 2 cycles, s2_flush for the first cycle only, pc_en=1 throughout. A trap_req plus hazard asserted during FLUSH -> hazard ignored; trap taken on return to RUN: freeze, TRAP, trap_ack_out=1 for exactly one cycle.
- Simultaneous trap_req, branch_taken and hazard in RUN -> trap wins (freeze, then TRAP); branch is not taken.
- Reset asserted mid-MEM_WAIT -> outputs forced to reset values immediately; after release state=RUN and stall_cnt_out=0.
